// File: rtl/bram_pkg.sv
// Shared types and width helpers for the BRAM request adapter.
package bram_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } bram_state_e;

  // Occupancy counters need one extra bit to represent "full".
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bram_rsp_fifo.sv
// Response FIFO: DATA_WIDTH x DEPTH, synchronous reset, occupancy count out.
module bram_rsp_fifo
  import bram_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 4,
  localparam int PW         = $clog2(DEPTH),
  localparam int CW         = cnt_width(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [CW-1:0]         count_o
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
  logic [PW-1:0]                    wr_ptr_q, rd_ptr_q;
  logic                             do_pop;

  assign do_pop  = pop_i && (count_o != '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage carries no reset; only pointers and count are cleared.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_o  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_o <= count_o + CW'(push_i) - CW'(do_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && !do_pop && (count_o == CW'(DEPTH))));

endmodule

// File: rtl/bram_req_adapter.sv
// Valid/ready front end for a 1-cycle-latency single-port BRAM with in-order read responses.
// Optional BRAM_ADAPTER_CLEAR_EN: zero-fill sweep of the whole BRAM after every reset.
module bram_req_adapter
  import bram_pkg::*;
#(
  parameter  int DATA_WIDTH     = 32,
  parameter  int BRAM_DEPTH     = 128,
  parameter  int RSP_FIFO_DEPTH = 4,
  localparam int ADDR_WIDTH     = $clog2(BRAM_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  bram_cmd_en_o,
  output logic                  bram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] bram_addr_o,
  output logic [DATA_WIDTH-1:0] bram_data_o,
  input  logic [DATA_WIDTH-1:0] bram_data_i,
  output logic                  busy_o
);

  localparam int CW = cnt_width(RSP_FIFO_DEPTH);

`ifdef BRAM_ADAPTER_CLEAR_EN
  localparam bram_state_e ST_RESET = ST_CLEAR;
`else
  localparam bram_state_e ST_RESET = ST_RUN;
`endif

  bram_state_e   state_q, state_d;
  logic          inflight_q;
  logic          accept, rd_issue, pop;
  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   used;

  // Credit: every outstanding read already owns a FIFO slot, so a push never lands on a full FIFO.
  assign used        = {1'b0, fifo_cnt} + (CW+1)'(inflight_q);
  assign req_ready_o = !rst_i && (state_q == ST_RUN) && (used < (CW+1)'(RSP_FIFO_DEPTH));
  assign accept      = req_valid_i && req_ready_o;
  assign rd_issue    = accept && !req_we_i;
  assign rsp_valid_o = (fifo_cnt != '0);
  assign pop         = rsp_valid_o && rsp_ready_i;

`ifdef BRAM_ADAPTER_CLEAR_EN
  logic [ADDR_WIDTH-1:0] clr_addr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)                   clr_addr_q <= '0;
    else if (state_q == ST_CLEAR) clr_addr_q <= clr_addr_q + 1'b1;
  end

  assign busy_o = !rst_i && (state_q == ST_CLEAR);
`else
  assign busy_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bram_cmd_en_o = accept;
    bram_wr_en_o  = accept && req_we_i;
    bram_addr_o   = accept ? req_addr_i : '0;
    bram_data_o   = (accept && req_we_i) ? req_wdata_i : '0;
    case (state_q)
      ST_CLEAR: begin
`ifdef BRAM_ADAPTER_CLEAR_EN
        if (!rst_i) begin
          bram_cmd_en_o = 1'b1;
          bram_wr_en_o  = 1'b1;
          bram_addr_o   = clr_addr_q;
          bram_data_o   = '0;
        end
        if (clr_addr_q == ADDR_WIDTH'(BRAM_DEPTH - 1)) state_d = ST_RUN;
`else
        state_d = ST_RUN;
`endif
      end
      default: ;
    endcase
  end

  // Read data is valid only in the cycle right after issue; capture it there.
  always_ff @(posedge clk_i) begin
    if (rst_i) inflight_q <= 1'b0;
    else       inflight_q <= rd_issue;
  end

  bram_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (inflight_q),
    .wdata_i (bram_data_i),
    .pop_i   (pop),
    .rdata_o (rsp_rdata_o),
    .count_o (fifo_cnt)
  );

endmodule
